fc_score_collector: RTL and testbench

FC_SCORE_COLLECTOR -- requirements
Module: fc_score_collector

---
 rtl/fc_score_collector.sv | 125 ++++++++++++
 tb/tb_fc_score_collector.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fc_score_collector.sv
// fc_score_collector
//   Packs ten FC class scores into one vector and holds it for the classifier.
//   Pulses a classify enable and captures the winning class index. The index
//   is then handed downstream on a valid/ready pair. If the classifier never
//   answers, a wait counter gives up and the block returns to collecting.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   score_vld/score/score_last/score_rdy
//                     upstream score stream, one class per beat, class 0 first
//   fc_result         packed scores, class 0 in the MSB slice
//   classify_en       classifier enable (registered); low clears the classifier
//   classify_res_vld/classify_res
//                     classifier answer
//   digit/digit_vld/digit_rdy
//                     captured class index to downstream
//   err_len           sticky: score_last seen on the wrong beat
//   err_timeout       sticky: classifier did not answer within TIMEOUT cycles
module fc_score_collector #(
    parameter int DATA_SIZE = 8,
    parameter int TIMEOUT   = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    score_vld,
    input  logic [DATA_SIZE-1:0]    score,
    input  logic                    score_last,
    output logic                    score_rdy,
    output logic [10*DATA_SIZE-1:0] fc_result,
    output logic                    classify_en,
    input  logic                    classify_res_vld,
    input  logic [DATA_SIZE-1:0]    classify_res,
    output logic [DATA_SIZE-1:0]    digit,
    output logic                    digit_vld,
    input  logic                    digit_rdy,
    output logic                    err_len,
    output logic                    err_timeout
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        CLASSIFY = 2'd1,
        DONE     = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [3:0]        k;
    logic [WAIT_W-1:0] wait_cnt;
    logic              beat;
    logic              last_beat;
    logic              cls_hit;
    logic              cls_tmo;

    assign beat      = score_vld && score_rdy;
    assign last_beat = (k == 4'd9);
    // classify_res_vld is only meaningful while classifying
    assign cls_hit   = (state == CLASSIFY) && classify_res_vld;
    // wait_cnt counts completed CLASSIFY cycles; the TIMEOUT-th one gives up
    assign cls_tmo   = (state == CLASSIFY) && !classify_res_vld &&
                       (wait_cnt == WAIT_W'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= COLLECT;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT:  if (beat && last_beat) state_nxt = CLASSIFY;
            CLASSIFY: begin
                if (cls_hit)      state_nxt = DONE;
                else if (cls_tmo) state_nxt = COLLECT;
            end
            DONE:     if (digit_rdy) state_nxt = COLLECT;
            default:  state_nxt = COLLECT;
        endcase
    end

    // Output decode
    always_comb begin
        score_rdy = (state == COLLECT);
    end

    // Datapath and registered outputs. classify_en and digit_vld are flopped
    // from the next state, so they track the state register without decode glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            k           <= '0;
            wait_cnt    <= '0;
            fc_result   <= '0;
            classify_en <= 1'b0;
            digit       <= '0;
            digit_vld   <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (beat) begin
                // Beat k lands in slice 9-k so class 0 ends up in the MSBs
                for (int i = 0; i < 10; i++) begin
                    if (k == 4'(i))
                        fc_result[(9-i)*DATA_SIZE +: DATA_SIZE] <= score;
                end
                k <= last_beat ? 4'd0 : k + 4'd1;
                // The frame length is fixed at ten beats; score_last is only checked
                if (score_last != last_beat) err_len <= 1'b1;
            end

            // Zero outside CLASSIFY, so it is already clear on entry
            if (state == CLASSIFY) wait_cnt <= wait_cnt + WAIT_W'(1);
            else                   wait_cnt <= '0;

            if (cls_hit) digit       <= classify_res;
            if (cls_tmo) err_timeout <= 1'b1;

            classify_en <= (state_nxt == CLASSIFY);
            digit_vld   <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_fc_score_collector.sv
// Directed bench for fc_score_collector. The classifier stand-in raises
// classify_res_vld on the sixth cycle of classify_en, with the argmax
// of fc_result. It can be muted to force a timeout.
module tb_fc_score_collector;

    localparam logic [79:0] ASC  = 80'h0A141E28323C46505A64;
    localparam logic [79:0] DESC = 80'h645A50463C32281E140A;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        score_vld = 1'b0;
    logic [7:0]  score = '0;
    logic        score_last = 1'b0;
    logic        score_rdy;
    logic [79:0] fc_result;
    logic        classify_en;
    logic        classify_res_vld = 1'b0;
    logic [7:0]  classify_res = '0;
    logic [7:0]  digit;
    logic        digit_vld;
    logic        digit_rdy = 1'b1;
    logic        err_len;
    logic        err_timeout;

    int   checks = 0;
    int   errors = 0;
    int   en_cnt = 0;
    bit   model_on = 1'b1;
    int   n;
    logic dv, rv;

    fc_score_collector #(.DATA_SIZE(8), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .score_vld(score_vld), .score(score), .score_last(score_last),
        .score_rdy(score_rdy), .fc_result(fc_result), .classify_en(classify_en),
        .classify_res_vld(classify_res_vld), .classify_res(classify_res),
        .digit(digit), .digit_vld(digit_vld), .digit_rdy(digit_rdy),
        .err_len(err_len), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] argmax(logic [79:0] v);
        logic [7:0] best = 8'd0;
        logic [7:0] bv   = v[79:72];
        for (int i = 1; i < 10; i++) begin
            if (v[(9-i)*8 +: 8] > bv) begin
                bv   = v[(9-i)*8 +: 8];
                best = 8'(i);
            end
        end
        return best;
    endfunction

    // Classifier stand-in: answers on its sixth enabled cycle
    always @(posedge clk) begin
        #2;
        if (classify_en && model_on) begin
            if (en_cnt == 5) begin
                classify_res_vld = 1'b1;
                classify_res     = argmax(fc_result);
            end else begin
                classify_res_vld = 1'b0;
            end
            en_cnt++;
        end else begin
            en_cnt           = 0;
            classify_res_vld = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [79:0] got, logic [79:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send_frame(bit desc, int last_pos, int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            score_vld  = 1'b1;
            score      = desc ? 8'(10 * (10 - i)) : 8'(10 * (i + 1));
            score_last = (i == last_pos);
            step();
        end
        score_vld  = 1'b0;
        score_last = 1'b0;
    endtask

    // Called with classify_en already high. Returns the count of cycles it
    // was high, whether digit_vld rose, and classify_res_vld at that moment.
    task automatic wait_cls(output int cnt, output logic saw_dv, output logic saw_rv);
        cnt = 1; saw_dv = 1'b0; saw_rv = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (digit_vld) begin
                saw_dv = 1'b1;
                saw_rv = classify_res_vld;
                return;
            end
            if (!classify_en) return;
            cnt++;
        end
        chk("wait_bound", 80'(digit_vld | ~classify_en), 80'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        step(); step();
        rst = 1'b0;
        chk("rst_score_rdy",   80'(score_rdy),   80'd1);
        chk("rst_classify_en", 80'(classify_en), 80'd0);
        chk("rst_digit_vld",   80'(digit_vld),   80'd0);
        chk("rst_digit",       80'(digit),       80'd0);
        chk("rst_fc_result",   fc_result,        80'd0);
        chk("rst_err_len",     80'(err_len),     80'd0);
        chk("rst_err_timeout", 80'(err_timeout), 80'd0);

        // Frame 1: nominal
        send_frame(1'b0, 9, 10);
        chk("f1_classify_en", 80'(classify_en), 80'd1);
        chk("f1_score_rdy",   80'(score_rdy),   80'd0);
        chk("f1_fc_result",   fc_result,        ASC);
        wait_cls(n, dv, rv);
        chk("f1_en_cycles",   80'(n),  80'd6);
        chk("f1_digit_vld",   80'(dv), 80'd1);
        chk("f1_res_vld_prev", 80'(rv), 80'd1);
        chk("f1_digit",       80'(digit),       80'd9);
        chk("f1_en_low",      80'(classify_en), 80'd0);
        chk("f1_err_len",     80'(err_len),     80'd0);
        step();
        chk("f1_dv_drop",     80'(digit_vld),   80'd0);
        chk("f1_rdy_back",    80'(score_rdy),   80'd1);

        // Frame 2: downstream stalls 5 cycles; stray scores while busy
        digit_rdy = 1'b0;
        send_frame(1'b0, 9, 10);
        score_vld = 1'b1;
        score     = 8'hFF;
        wait_cls(n, dv, rv);
        score_vld = 1'b0;
        chk("f2_en_cycles", 80'(n),  80'd6);
        chk("f2_digit_vld", 80'(dv), 80'd1);
        for (int i = 0; i < 5; i++) begin
            chk("f2_hold_dv",  80'(digit_vld), 80'd1);
            chk("f2_hold_dig", 80'(digit),     80'd9);
            chk("f2_hold_rdy", 80'(score_rdy), 80'd0);
            if (i < 4) step();
        end
        digit_rdy = 1'b1;
        step();
        chk("f2_dv_drop",   80'(digit_vld), 80'd0);
        chk("f2_rdy_back",  80'(score_rdy), 80'd1);
        chk("f2_fc_stable", fc_result,      ASC);

        // Frame 3: score_last on beat 4
        send_frame(1'b0, 4, 10);
        chk("f3_err_len",   80'(err_len),     80'd1);
        chk("f3_classify",  80'(classify_en), 80'd1);
        wait_cls(n, dv, rv);
        chk("f3_en_cycles", 80'(n),     80'd6);
        chk("f3_digit",     80'(digit), 80'd9);
        step();

        // Frame 4: classifier silent -> timeout
        model_on = 1'b0;
        send_frame(1'b0, 9, 10);
        wait_cls(n, dv, rv);
        chk("f4_en_cycles",  80'(n),           80'd15);
        chk("f4_no_dv",      80'(dv),          80'd0);
        chk("f4_err_tmo",    80'(err_timeout), 80'd1);
        chk("f4_en_low",     80'(classify_en), 80'd0);
        chk("f4_rdy",        80'(score_rdy),   80'd1);
        step();
        chk("f4_no_dv_late", 80'(digit_vld),   80'd0);
        model_on = 1'b1;

        // Recovery frame, argmax at class 0
        send_frame(1'b1, 9, 10);
        chk("f5_fc_result", fc_result, DESC);
        wait_cls(n, dv, rv);
        chk("f5_digit_vld", 80'(dv),    80'd1);
        chk("f5_digit",     80'(digit), 80'd0);
        step();

        // Reset mid-frame after beat 6
        send_frame(1'b0, 9, 7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("r_fc_result", fc_result,         80'd0);
        chk("r_err_len",   80'(err_len),      80'd0);
        chk("r_err_tmo",   80'(err_timeout),  80'd0);
        chk("r_digit",     80'(digit),        80'd0);
        chk("r_en",        80'(classify_en),  80'd0);
        chk("r_rdy",       80'(score_rdy),    80'd1);
        send_frame(1'b0, 9, 10);
        chk("r_fc_full",   fc_result, ASC);
        wait_cls(n, dv, rv);
        chk("r_digit9",    80'(digit), 80'd9);
        step();

        // Back-to-back frames, digit_rdy high
        send_frame(1'b0, 9, 10);
        wait_cls(n, dv, rv);
        chk("b1_digit", 80'(digit),       80'd9);
        chk("b1_gap",   80'(classify_en), 80'd0);
        step();
        chk("b1_rdy",   80'(score_rdy),   80'd1);
        send_frame(1'b1, 9, 10);
        wait_cls(n, dv, rv);
        chk("b2_dv",    80'(dv),    80'd1);
        chk("b2_digit", 80'(digit), 80'd0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
